knapsack_fitness_evaluator: RTL and testbench

- Fitness responder for the compact GA controller.
- Accepts an individual when `test_individual` is asserted.
- Scores it as a 0/1 knapsack solution, scanning ChunkWidth genes per cycle.
- Returns the score on `fitness` with a one-cycle `fitness_end` pulse, matching the controller's daughter/son evaluation handshake.

---
 rtl/knapsack_fitness_evaluator_pkg.sv | 26 ++
 rtl/knapsack_fitness_evaluator_chunk_adder.sv | 27 ++
 rtl/knapsack_fitness_evaluator.sv | 162 ++++++++++++++++
 tb/tb_knapsack_fitness_evaluator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/knapsack_fitness_evaluator_pkg.sv
// Shared definitions for the knapsack fitness evaluator: FSM state encoding,
// accumulator sizing and the unsigned saturation helper.
`ifndef KNAPSACK_FITNESS_EVALUATOR_PKG_SV
`define KNAPSACK_FITNESS_EVALUATOR_PKG_SV
package knapsack_fitness_evaluator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SCORE = 2'd2,
        ST_DONE  = 2'd3
    } kfe_state_e;

    // One spare bit over the worst-case sum of every item.
    function automatic int acc_width(input int individual_width, input int item_width);
        return item_width + $clog2(individual_width) + 1;
    endfunction

    function automatic logic [63:0] sat_unsigned(input logic [63:0] x, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (x > max_val) ? max_val : x;
    endfunction

endpackage
`endif

// File: rtl/knapsack_fitness_evaluator_chunk_adder.sv
// Combinational adder summing the value and weight of the selected genes of one chunk.
module knapsack_chunk_adder
    import knapsack_fitness_evaluator_pkg::*;
#(
    parameter int ChunkWidth = 4,
    parameter int ItemWidth  = 8,
    parameter int AccWidth   = 14
) (
    input  logic [ChunkWidth-1:0]           genes,
    input  logic [ChunkWidth*ItemWidth-1:0] values,
    input  logic [ChunkWidth*ItemWidth-1:0] weights,
    output logic [AccWidth-1:0]             value_sum,
    output logic [AccWidth-1:0]             weight_sum
);

    always_comb begin
        value_sum  = '0;
        weight_sum = '0;
        for (int i = 0; i < ChunkWidth; i++) begin
            if (genes[i]) begin
                value_sum  = value_sum + AccWidth'(values[i*ItemWidth +: ItemWidth]);
                weight_sum = weight_sum + AccWidth'(weights[i*ItemWidth +: ItemWidth]);
            end
        end
    end

endmodule

// File: rtl/knapsack_fitness_evaluator.sv
// Scores a GA individual as a 0/1 knapsack solution, ChunkWidth genes per cycle,
// and answers with a registered fitness and a single-cycle fitness_end pulse.
module knapsack_fitness_evaluator
    import knapsack_fitness_evaluator_pkg::*;
#(
    parameter int IndividualWidth = 32,
    parameter int FitnessWidth    = 16,
    parameter int ItemWidth       = 8,
    parameter int ChunkWidth      = 4,
    parameter int PenaltyShift    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 test_individual,
    input  logic [IndividualWidth-1:0]           individual,
    input  logic [IndividualWidth*ItemWidth-1:0] item_values,
    input  logic [IndividualWidth*ItemWidth-1:0] item_weights,
    input  logic [FitnessWidth-1:0]              capacity,
    output logic [FitnessWidth-1:0]              fitness,
    output logic                                 fitness_end,
    output logic                                 busy
);

    localparam int NumChunks = IndividualWidth / ChunkWidth;
    localparam int AccWidth  = acc_width(IndividualWidth, ItemWidth);
    localparam int IdxWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int ChunkBits = ChunkWidth * ItemWidth;
    localparam int WideWidth = AccWidth + PenaltyShift + FitnessWidth + 1;

    if (IndividualWidth % ChunkWidth != 0) begin : g_bad_chunking
        $error("IndividualWidth must be a multiple of ChunkWidth");
    end

    kfe_state_e                 state_q, state_d;
    logic [IndividualWidth-1:0] individual_q, individual_d;
    logic [AccWidth-1:0]        value_sum_q, value_sum_d;
    logic [AccWidth-1:0]        weight_sum_q, weight_sum_d;
    logic [IdxWidth-1:0]        idx_q, idx_d;
    logic [FitnessWidth-1:0]    fitness_q, fitness_d;
    logic                       fitness_end_q, fitness_end_d;
    logic                       busy_q, busy_d;

    logic [ChunkWidth-1:0] chunk_genes;
    logic [ChunkBits-1:0]  chunk_values;
    logic [ChunkBits-1:0]  chunk_weights;
    logic [AccWidth-1:0]   chunk_value_sum;
    logic [AccWidth-1:0]   chunk_weight_sum;

    always_comb begin
        chunk_genes   = individual_q[ChunkWidth-1:0];
        chunk_values  = item_values[ChunkBits-1:0];
        chunk_weights = item_weights[ChunkBits-1:0];
        for (int k = 0; k < NumChunks; k++) begin
            if (idx_q == IdxWidth'(k)) begin
                chunk_genes   = individual_q[k*ChunkWidth +: ChunkWidth];
                chunk_values  = item_values[k*ChunkBits +: ChunkBits];
                chunk_weights = item_weights[k*ChunkBits +: ChunkBits];
            end
        end
    end

    knapsack_chunk_adder #(
        .ChunkWidth(ChunkWidth),
        .ItemWidth (ItemWidth),
        .AccWidth  (AccWidth)
    ) u_chunk_adder (
        .genes     (chunk_genes),
        .values    (chunk_values),
        .weights   (chunk_weights),
        .value_sum (chunk_value_sum),
        .weight_sum(chunk_weight_sum)
    );

    // Penalised score; everything is widened so the excess shift cannot wrap.
    logic [FitnessWidth-1:0] value_sat;
    logic [WideWidth-1:0]    value_wide, weight_wide, cap_wide, penalty;
    logic [FitnessWidth-1:0] score;

    always_comb begin
        value_sat   = FitnessWidth'(sat_unsigned(64'(value_sum_q), FitnessWidth));
        value_wide  = WideWidth'(value_sat);
        weight_wide = WideWidth'(weight_sum_q);
        cap_wide    = WideWidth'(capacity);
        penalty     = (weight_wide - cap_wide) << PenaltyShift;
        if (weight_wide <= cap_wide) begin
            score = value_sat;
        end else if (penalty >= value_wide) begin
            score = '0;
        end else begin
            score = FitnessWidth'(value_wide - penalty);
        end
    end

    always_comb begin
        state_d       = state_q;
        individual_d  = individual_q;
        value_sum_d   = value_sum_q;
        weight_sum_d  = weight_sum_q;
        idx_d         = idx_q;
        fitness_d     = fitness_q;
        fitness_end_d = 1'b0;
        busy_d        = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (test_individual) begin
                    individual_d = individual;
                    value_sum_d  = '0;
                    weight_sum_d = '0;
                    idx_d        = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                value_sum_d  = value_sum_q + chunk_value_sum;
                weight_sum_d = weight_sum_q + chunk_weight_sum;
                if (idx_q == IdxWidth'(NumChunks - 1)) begin
                    state_d = ST_SCORE;
                end else begin
                    idx_d = idx_q + IdxWidth'(1);
                end
            end
            ST_SCORE: begin
                fitness_d     = score;
                fitness_end_d = 1'b1;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            individual_q  <= '0;
            value_sum_q   <= '0;
            weight_sum_q  <= '0;
            idx_q         <= '0;
            fitness_q     <= '0;
            fitness_end_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            individual_q  <= individual_d;
            value_sum_q   <= value_sum_d;
            weight_sum_q  <= weight_sum_d;
            idx_q         <= idx_d;
            fitness_q     <= fitness_d;
            fitness_end_q <= fitness_end_d;
            busy_q        <= busy_d;
        end
    end

    assign fitness     = fitness_q;
    assign fitness_end = fitness_end_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_knapsack_fitness_evaluator.sv
// Directed and randomised bench for the knapsack fitness evaluator (8 genes, 2 per cycle).
module tb_knapsack_fitness_evaluator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        test_individual = 1'b0;
    logic [7:0]  individual = '0;
    logic [63:0] item_values = '0;
    logic [63:0] item_weights = '0;
    logic [15:0] capacity = '0;
    logic [15:0] fitness;
    logic        fitness_end;
    logic        busy;
    logic [7:0]  fitness8;
    logic        fitness_end8;
    logic        busy8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    knapsack_fitness_evaluator #(
        .IndividualWidth(8), .FitnessWidth(16), .ItemWidth(8), .ChunkWidth(2), .PenaltyShift(1)
    ) dut (
        .clk(clk), .rst(rst), .test_individual(test_individual), .individual(individual),
        .item_values(item_values), .item_weights(item_weights), .capacity(capacity),
        .fitness(fitness), .fitness_end(fitness_end), .busy(busy)
    );

    knapsack_fitness_evaluator #(
        .IndividualWidth(8), .FitnessWidth(8), .ItemWidth(8), .ChunkWidth(2), .PenaltyShift(1)
    ) dut8 (
        .clk(clk), .rst(rst), .test_individual(test_individual), .individual(individual),
        .item_values(item_values), .item_weights(item_weights), .capacity(capacity[7:0]),
        .fitness(fitness8), .fitness_end(fitness_end8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input logic [7:0] ind, input logic [63:0] v, input logic [63:0] w,
                                 input int cap, input int fw);
        int vs, ws, mx, vsat, p;
        vs = 0;
        ws = 0;
        for (int i = 0; i < 8; i++) begin
            if (ind[i]) begin
                vs += int'(v[i*8 +: 8]);
                ws += int'(w[i*8 +: 8]);
            end
        end
        mx   = (1 << fw) - 1;
        vsat = (vs > mx) ? mx : vs;
        if (ws <= cap) return vsat;
        p = (ws - cap) * 2;
        return (p >= vsat) ? 0 : vsat - p;
    endfunction

    // One-cycle request, then observe 12 cycles; cycle c is sampled after edge c (edge 0 = accept).
    task automatic run_req(input logic [7:0] ind, output int fit16, output int fit8,
                           output int first_end, output int pulses, output int pulses8,
                           output int busy_cnt, output int dbl);
        logic prev;
        @(negedge clk);
        test_individual = 1'b1;
        individual      = ind;
        @(posedge clk);
        #1 test_individual = 1'b0;
        fit16 = -1; fit8 = -1; first_end = -1;
        pulses = 0; pulses8 = 0; busy_cnt = 0; dbl = 0; prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (fitness_end && prev) dbl++;
            prev = fitness_end;
            if (fitness_end) begin
                pulses++;
                fit16 = int'(fitness);
                if (first_end < 0) first_end = c;
            end
            if (fitness_end8) begin
                pulses8++;
                fit8 = int'(fitness8);
            end
        end
    endtask

    int f16, f8, fe, np, np8, bc, db, c_end;
    logic [7:0] rind;

    initial begin
        item_values  = {8{8'd10}};
        item_weights = {8{8'd5}};
        capacity     = 16'd20;
        repeat (2) @(negedge clk);
        check("reset_fitness", fitness, 0);
        check("reset_fitness_end", fitness_end, 0);
        check("reset_busy", busy, 0);
        check("reset_busy8", busy8, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_req(8'h0F, f16, f8, fe, np, np8, bc, db);
        check("basic_fitness", f16, 40);
        check("basic_latency", fe, 5);
        check("basic_pulses", np, 1);
        check("basic_busy_cycles", bc, 6);
        check("basic_fitness8", f8, 40);
        check("basic_hold", fitness, 40);

        run_req(8'hFF, f16, f8, fe, np, np8, bc, db);
        check("overweight_fitness", f16, 40);
        run_req(8'h00, f16, f8, fe, np, np8, bc, db);
        check("empty_fitness", f16, 0);
        check("empty_pulses", np, 1);

        item_values  = {8{8'd255}};
        item_weights = {8{8'd0}};
        run_req(8'hFF, f16, f8, fe, np, np8, bc, db);
        check("sat_fitness8", f8, 255);
        check("nosat_fitness16", f16, 2040);

        item_values  = {8{8'd1}};
        item_weights = {8{8'd100}};
        capacity     = 16'd0;
        run_req(8'h01, f16, f8, fe, np, np8, bc, db);
        check("floor_fitness8", f8, 0);
        check("floor_fitness16", f16, 0);

        // Back-to-back: re-raise on the edge that sees fitness_end.
        item_values  = {8{8'd10}};
        item_weights = {8{8'd5}};
        capacity     = 16'd20;
        @(negedge clk);
        test_individual = 1'b1;
        individual      = 8'h0F;
        @(posedge clk);
        #1 test_individual = 1'b0;
        c_end = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (fitness_end) begin
                c_end = c;
                break;
            end
        end
        check("b2b_first_latency", c_end, 5);
        check("b2b_first_fitness", fitness, 40);
        @(posedge clk);
        #1 test_individual = 1'b1;
        individual = 8'h03;
        check("b2b_pulse_dropped", fitness_end, 0);
        check("b2b_idle", busy, 0);
        @(posedge clk);
        #1 test_individual = 1'b0;
        check("b2b_accepted", busy, 1);
        fe = -1; np = 0; f16 = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (fitness_end) begin
                np++;
                f16 = int'(fitness);
                if (fe < 0) fe = c;
            end
        end
        check("b2b_second_fitness", f16, 20);
        check("b2b_second_latency", fe, 5);
        check("b2b_second_pulses", np, 1);

        // Requests toggled while scanning must be ignored.
        @(negedge clk);
        test_individual = 1'b1;
        individual      = 8'h0F;
        @(posedge clk);
        #1 test_individual = 1'b0;
        fe = -1; np = 0; f16 = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (fitness_end) begin
                np++;
                f16 = int'(fitness);
                if (fe < 0) fe = c;
            end
            if (c == 1 || c == 3) begin
                test_individual = 1'b1;
                individual      = 8'hFF;
            end else begin
                test_individual = 1'b0;
            end
        end
        check("ignore_pulses", np, 1);
        check("ignore_fitness", f16, 40);
        check("ignore_latency", fe, 5);
        check("ignore_idle_after", busy, 0);

        // Asynchronous reset in the middle of SCAN.
        @(negedge clk);
        test_individual = 1'b1;
        individual      = 8'h0F;
        @(posedge clk);
        #1 test_individual = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_fitness", fitness, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_fitness_end", fitness_end, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        np = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fitness_end) np++;
        end
        check("async_rst_no_pulse", np, 0);
        run_req(8'h0F, f16, f8, fe, np, np8, bc, db);
        check("post_rst_fitness", f16, 40);
        check("post_rst_latency", fe, 5);

        // Randomised requests against the reference model.
        for (int n = 0; n < 1000; n++) begin
            item_values  = {$urandom, $urandom};
            item_weights = {$urandom, $urandom};
            capacity     = 16'($urandom_range(0, 2100));
            rind         = 8'($urandom);
            run_req(rind, f16, f8, fe, np, np8, bc, db);
            check("rand_fitness16", f16,
                  model(rind, item_values, item_weights, int'(capacity), 16));
            check("rand_fitness8", f8,
                  model(rind, item_values, item_weights, int'(capacity[7:0]), 8));
            check("rand_single_pulse", np + np8 + db, 2);
            check("rand_latency", fe, 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
